sad_min_search: RTL and testbench

- Downstream consumer of the SAD engine's result SRAM (128 x 32-bit entries, 7-bit address).
- After the SAD engine signals Done, a Go pulse starts a sequential scan of all result entries.
- The scan finds the minimum SAD value and its index, and counts the entries strictly below a programmable threshold.
- The block owns the result SRAM's port while Busy; the SAD engine must be idle during a scan.

---
 rtl/sad_pkg.sv | 27 ++
 rtl/sad_min_acc.sv | 81 ++++++++
 rtl/sad_min_search.sv | 112 +++++++++++
 tb/tb_sad_min_search.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
//------------------------------------------------------------------------------
// Module  : sad_pkg
// Brief   : Constants, state encoding and RW encoding shared by the SAD blocks
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sad_pkg;

  localparam int C_A_WIDTH   = 7;
  localparam int C_D_WIDTH   = 32;
  localparam int NUM_ENTRIES = 128;
  localparam int CNT_WIDTH   = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sad_min_acc.sv
//------------------------------------------------------------------------------
// Module  : sad_min_acc
// Brief   : Running minimum / index / below-threshold count over a read stream
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sad_min_acc #(
  parameter int A_W   = 7,
  parameter int D_W   = 32,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clear,
  input  logic [D_W-1:0]   Thresh,
  input  logic             Vld,
  input  logic [D_W-1:0]   Data,
  input  logic [A_W-1:0]   Idx,
  input  logic             Commit,
  output logic [D_W-1:0]   Min_SAD,
  output logic [A_W-1:0]   Min_Idx,
  output logic [CNT_W-1:0] Below_Cnt
);

  logic [D_W-1:0]   r_thresh;
  logic [D_W-1:0]   r_min;
  logic [A_W-1:0]   r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;

  logic             w_take;
  logic             w_below;
  logic [D_W-1:0]   w_min_nxt;
  logic [A_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Strict less-than keeps the earlier index on ties
  assign w_take    = Vld && (r_first || (Data < r_min));
  assign w_below   = Vld && (Data < r_thresh);
  assign w_min_nxt = w_take ? Data : r_min;
  assign w_idx_nxt = w_take ? Idx  : r_idx;
  assign w_cnt_nxt = r_cnt + CNT_W'(w_below);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_thresh <= '0;
      r_min    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
    end else if (Clear) begin
      r_thresh <= Thresh;
      r_min    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b1;
    end else if (Vld) begin
      r_min    <= w_min_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_first  <= 1'b0;
    end
  end

  // The last entry is consumed on the commit edge, so publish the next-state values
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Min_SAD   <= '0;
      Min_Idx   <= '0;
      Below_Cnt <= '0;
    end else if (Commit) begin
      Min_SAD   <= w_min_nxt;
      Min_Idx   <= w_idx_nxt;
      Below_Cnt <= w_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sad_min_search.sv
//------------------------------------------------------------------------------
// Module  : sad_min_search
// Brief   : Scans the SAD result SRAM for the minimum and a below-threshold count
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sad_min_search #(
  parameter int C_A_WIDTH   = sad_pkg::C_A_WIDTH,
  parameter int C_D_WIDTH   = sad_pkg::C_D_WIDTH,
  parameter int NUM_ENTRIES = sad_pkg::NUM_ENTRIES,
  parameter int CNT_WIDTH   = sad_pkg::CNT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Go,
  input  logic [C_D_WIDTH-1:0] Thresh,
  output logic [C_A_WIDTH-1:0] C_Addr,
  output logic                 C_RW,
  output logic                 C_En,
  input  logic [C_D_WIDTH-1:0] C_Data,
  output logic                 Busy,
  output logic                 Done,
  output logic [C_D_WIDTH-1:0] Min_SAD,
  output logic [C_A_WIDTH-1:0] Min_Idx,
  output logic [CNT_WIDTH-1:0] Below_Cnt
);

  import sad_pkg::*;

  localparam logic [C_A_WIDTH-1:0] C_LAST_ADDR = C_A_WIDTH'(NUM_ENTRIES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_go_acc;
  logic [C_A_WIDTH-1:0] w_addr_nxt;

  // Stage 0: address on the SRAM port; stage 1: its read data on C_Data
  logic [1:0]           r_vld;
  logic [C_A_WIDTH-1:0] r_idx [2];

  always_comb begin
    w_state_nxt = r_state;
    w_go_acc    = 1'b0;
    w_addr_nxt  = r_idx[0];
    case (r_state)
      IDLE, DONE: begin
        if (Go) begin
          w_state_nxt = SCAN;
          w_go_acc    = 1'b1;
          w_addr_nxt  = '0;
        end
      end
      SCAN: begin
        if (r_idx[0] == C_LAST_ADDR) begin
          w_state_nxt = DRAIN;
        end else begin
          w_addr_nxt = r_idx[0] + C_A_WIDTH'(1);
        end
      end
      DRAIN:   w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_vld    <= '0;
      r_idx[0] <= '0;
      r_idx[1] <= '0;
    end else begin
      r_vld    <= {r_vld[0], (w_state_nxt == SCAN)};
      r_idx[0] <= w_addr_nxt;
      r_idx[1] <= r_idx[0];
    end
  end

  assign C_Addr = r_idx[0];
  assign C_En   = r_vld[0];
  assign C_RW   = RW_READ;
  assign Busy   = (r_state == SCAN) || (r_state == DRAIN);
  assign Done   = (r_state == DONE);

  sad_min_acc #(
    .A_W   (C_A_WIDTH),
    .D_W   (C_D_WIDTH),
    .CNT_W (CNT_WIDTH)
  ) u_acc (
    .Clk       (Clk),
    .Rst       (Rst),
    .Clear     (w_go_acc),
    .Thresh    (Thresh),
    .Vld       (r_vld[1]),
    .Data      (C_Data),
    .Idx       (r_idx[1]),
    .Commit    (r_state == DRAIN),
    .Min_SAD   (Min_SAD),
    .Min_Idx   (Min_Idx),
    .Below_Cnt (Below_Cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_sad_min_search.sv
//------------------------------------------------------------------------------
// Module  : tb_sad_min_search
// Brief   : Scoreboard bench for sad_min_search with a behavioural result SRAM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sad_min_search;

  typedef struct packed {
    logic [31:0] min_v;
    logic [6:0]  idx;
    logic [7:0]  cnt;
  } exp_t;

  logic        Clk;
  logic        Rst;
  logic        Go;
  logic [31:0] Thresh;
  logic [6:0]  C_Addr;
  logic        C_RW;
  logic        C_En;
  logic [31:0] sram_q;
  logic        Busy;
  logic        Done;
  logic [31:0] Min_SAD;
  logic [6:0]  Min_Idx;
  logic [7:0]  Below_Cnt;

  logic [31:0] mem [128];
  exp_t        sb [$];
  exp_t        prev;

  int n_checks = 0;
  int n_fail   = 0;
  int run_len  = 0;
  int last_run = 0;
  int seq_bad  = 0;
  int rw_bad   = 0;

  sad_min_search dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Go        (Go),
    .Thresh    (Thresh),
    .C_Addr    (C_Addr),
    .C_RW      (C_RW),
    .C_En      (C_En),
    .C_Data    (sram_q),
    .Busy      (Busy),
    .Done      (Done),
    .Min_SAD   (Min_SAD),
    .Min_Idx   (Min_Idx),
    .Below_Cnt (Below_Cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (C_En) sram_q <= mem[C_Addr];
  end

  // Port protocol monitor: RW always read, one gap-free 0..127 burst per scan
  always @(negedge Clk) begin
    if (!Rst) begin
      run_len = 0;
    end else begin
      if (C_RW !== 1'b0) rw_bad++;
      if (C_En === 1'b1) begin
        if (int'(C_Addr) != run_len) seq_bad++;
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] thr);
    exp_t e;
    e = '0;
    for (int i = 0; i < 128; i++) begin
      if (i == 0 || mem[i] < e.min_v) begin
        e.min_v = mem[i];
        e.idx   = 7'(i);
      end
      if (mem[i] < thr) e.cnt = e.cnt + 8'd1;
    end
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    check({tag, "_done"}, 64'(Done), 64'd0);
    check({tag, "_en"},   64'(C_En), 64'd0);
    check({tag, "_addr"}, 64'(C_Addr), 64'd0);
    check({tag, "_min"},  64'(Min_SAD), 64'd0);
    check({tag, "_idx"},  64'(Min_Idx), 64'd0);
    check({tag, "_cnt"},  64'(Below_Cnt), 64'd0);
  endtask

  task automatic run_scan(input logic [31:0] thr, input int go_again_at);
    exp_t e;
    int   n;
    int   busy_n;
    sb.push_back(model(thr));
    @(negedge Clk);
    Go     = 1'b1;
    Thresh = thr;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    check("done_clr", 64'(Done), 64'd0);
    check("busy_set", 64'(Busy), 64'd1);
    busy_n = 1;
    n      = 0;
    while (!Done && n < 300) begin
      if (n == go_again_at) begin
        Go     = 1'b1;
        Thresh = ~thr;
      end else begin
        Go = 1'b0;
      end
      @(posedge Clk);
      #1;
      n++;
      if (Busy) busy_n++;
      if (n == 64) begin
        check("hold_min", 64'(Min_SAD), 64'(prev.min_v));
        check("hold_idx", 64'(Min_Idx), 64'(prev.idx));
        check("hold_cnt", 64'(Below_Cnt), 64'(prev.cnt));
      end
    end
    Go     = 1'b0;
    Thresh = thr;
    check("latency", 64'(n), 64'd129);
    check("busy_len", 64'(busy_n), 64'd129);
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("min_sad", 64'(Min_SAD), 64'(e.min_v));
      check("min_idx", 64'(Min_Idx), 64'(e.idx));
      check("below_cnt", 64'(Below_Cnt), 64'(e.cnt));
      prev = e;
    end
    check("en_run", 64'(last_run), 64'd128);
    check("addr_seq", 64'(seq_bad), 64'd0);
    check("rw_read", 64'(rw_bad), 64'd0);
    last_run = 0;
  endtask

  initial begin
    Rst    = 1'b0;
    Go     = 1'b0;
    Thresh = '0;
    prev   = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    #12;
    check_zero("reset");
    @(posedge Clk);
    #1;
    Rst = 1'b1;

    // Descending ramp: minimum at the last entry
    for (int i = 0; i < 128; i++) mem[i] = 32'(1000 - i);
    run_scan(32'd900, -1);

    // Flat memory, threshold equal to the values
    for (int i = 0; i < 128; i++) mem[i] = 32'h10;
    run_scan(32'h10, -1);

    // Tie between entries 5 and 64, full-range threshold
    for (int i = 0; i < 128; i++) mem[i] = 32'h100;
    mem[5]  = 32'h3;
    mem[64] = 32'h3;
    run_scan(32'hFFFF_FFFF, -1);

    // Random data, Go and Thresh disturbed mid-scan, then a back-to-back scan
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    run_scan($urandom, 40);
    for (int i = 0; i < 128; i++) mem[i] = $urandom_range(5000, 0);
    run_scan(32'd2500, -1);

    // All-ones entries with zero threshold
    for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
    run_scan(32'd0, -1);

    // Asynchronous reset mid-scan, then a clean full scan
    for (int i = 0; i < 128; i++) mem[i] = 32'(1000 - i);
    @(negedge Clk);
    Go     = 1'b1;
    Thresh = 32'd900;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    repeat (59) @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check_zero("abort");
    @(posedge Clk);
    #1;
    Rst      = 1'b1;
    prev     = '0;
    last_run = 0;
    run_scan(32'd900, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
